// File: rtl/riscv_formal_monitor_rv32imc.sv
// riscv_formal_monitor_rv32imc
//
// RVFI commit checker for an NRET-wide retire RV32IMC core. It keeps a shadow
// register file, the expected retire order and the expected PC. It checks
// every retired instruction against them and latches the first violation as
// a sticky error code.
//
// Optional feature macro: RVFI_HALT_CHECK_EN. When it is defined, the checker
// raises check 9 for any commit after a halt. When it is undefined, rvfi_halt
// is ignored.
//
// Ports (channel c uses slice [c*W +: W] of every bus):
//   clock, reset          clock; asynchronous active-low reset
//   rvfi_valid            per-channel commit valid
//   rvfi_order            64-bit retire sequence number
//   rvfi_insn             instruction word (compressed when insn[1:0] != 2'b11)
//   rvfi_trap/halt/intr   trap, halt and interrupt flags (intr is ignored)
//   rvfi_mode             privilege mode (ignored)
//   rvfi_rs1/rs2_*        source register index and value read
//   rvfi_rd_*             destination index (0 = no write) and value
//   rvfi_pc_rdata/wdata   PC of the instruction and next PC
//   rvfi_mem_*            memory address, masks and data (only masks are checked)
//   errcode               0 = clean, else {8'h0, check[3:0], channel[3:0]}
//
// Handshake: there is no back-pressure. A channel carries a commit exactly in
// the cycle in which its rvfi_valid bit is high. Payload on invalid channels
// is don't-care, and an invalid channel never breaks the in-cycle chaining of
// order, PC and register forwarding.

module riscv_formal_monitor_rv32imc #(
  parameter int NRET = 8,
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [64*NRET-1:0]   rvfi_order,
  input  logic [ILEN*NRET-1:0] rvfi_insn,
  input  logic [NRET-1:0]      rvfi_trap,
  input  logic [NRET-1:0]      rvfi_halt,
  input  logic [NRET-1:0]      rvfi_intr,
  input  logic [2*NRET-1:0]    rvfi_mode,
  input  logic [5*NRET-1:0]    rvfi_rs1_addr,
  input  logic [5*NRET-1:0]    rvfi_rs2_addr,
  input  logic [XLEN*NRET-1:0] rvfi_rs1_rdata,
  input  logic [XLEN*NRET-1:0] rvfi_rs2_rdata,
  input  logic [5*NRET-1:0]    rvfi_rd_addr,
  input  logic [XLEN*NRET-1:0] rvfi_rd_wdata,
  input  logic [XLEN*NRET-1:0] rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0] rvfi_pc_wdata,
  input  logic [XLEN*NRET-1:0] rvfi_mem_addr,
  input  logic [4*NRET-1:0]    rvfi_mem_rmask,
  input  logic [4*NRET-1:0]    rvfi_mem_wmask,
  input  logic [XLEN*NRET-1:0] rvfi_mem_rdata,
  input  logic [XLEN*NRET-1:0] rvfi_mem_wdata,
  input  logic [NRET-1:0]      rvfi_mem_extamo,
  output logic [15:0]          errcode
);

  // Registered checker state
  logic [63:0]     exp_order_q;
  logic [XLEN-1:0] exp_pc_q;
  logic            pc_known_q;
  logic [XLEN-1:0] shadow_q [32];
  logic [31:0]     sval_q;
  logic            halted_q;

  // Next-state values after all channels of this cycle are applied
  logic [63:0]     ord_v;
  logic [XLEN-1:0] pc_v;
  logic            known_v;
  logic [XLEN-1:0] shadow_v [32];
  logic [31:0]     sval_v;
  logic            halted_v;
  logic [15:0]     first_v;

  // Per-channel working values
  logic [63:0]     ord_c;
  logic [ILEN-1:0] insn_c;
  logic [4:0]      rs1_c, rs2_c, rd_c;
  logic [XLEN-1:0] rs1_d, rs2_d, rd_d, pcr_c, pcw_c;
  logic [3:0]      rm_c, wm_c;
  logic [9:1]      fails;
  logic [3:0]      chk;

  // Fold the inputs that are intentionally not checked into one unused net.
  logic unused_inputs;
  assign unused_inputs = ^{rvfi_intr, rvfi_mode, rvfi_mem_addr, rvfi_mem_rdata,
                           rvfi_mem_wdata, rvfi_mem_extamo, rvfi_halt};

  // Legal byte masks: none, byte, aligned half, full word.
  function automatic logic mask_ok(input logic [3:0] m);
    return (m inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                      4'b0011, 4'b1100, 4'b1111});
  endfunction

  always_comb begin
    ord_v    = exp_order_q;
    pc_v     = exp_pc_q;
    known_v  = pc_known_q;
    shadow_v = shadow_q;
    sval_v   = sval_q;
    halted_v = halted_q;
    first_v  = '0;
    ord_c    = '0;
    insn_c   = '0;
    rs1_c    = '0;
    rs2_c    = '0;
    rd_c     = '0;
    rs1_d    = '0;
    rs2_d    = '0;
    rd_d     = '0;
    pcr_c    = '0;
    pcw_c    = '0;
    rm_c     = '0;
    wm_c     = '0;
    fails    = '0;
    chk      = '0;
    // Channels are walked in ascending index. Each valid channel sees the
    // order, PC and register updates of the valid channels below it.
    for (int c = 0; c < NRET; c++) begin
      if (rvfi_valid[c]) begin
        ord_c  = rvfi_order[c*64 +: 64];
        insn_c = rvfi_insn[c*ILEN +: ILEN];
        rs1_c  = rvfi_rs1_addr[c*5 +: 5];
        rs2_c  = rvfi_rs2_addr[c*5 +: 5];
        rd_c   = rvfi_rd_addr[c*5 +: 5];
        rs1_d  = rvfi_rs1_rdata[c*XLEN +: XLEN];
        rs2_d  = rvfi_rs2_rdata[c*XLEN +: XLEN];
        rd_d   = rvfi_rd_wdata[c*XLEN +: XLEN];
        pcr_c  = rvfi_pc_rdata[c*XLEN +: XLEN];
        pcw_c  = rvfi_pc_wdata[c*XLEN +: XLEN];
        rm_c   = rvfi_mem_rmask[c*4 +: 4];
        wm_c   = rvfi_mem_wmask[c*4 +: 4];

        fails    = '0;
        fails[1] = (ord_c != ord_v);
        fails[2] = (rd_c == 5'd0) && (rd_d != '0);
        fails[3] = (rs1_c != 5'd0) && sval_v[rs1_c] && (rs1_d != shadow_v[rs1_c]);
        fails[4] = (rs2_c != 5'd0) && sval_v[rs2_c] && (rs2_d != shadow_v[rs2_c]);
        fails[5] = known_v && (pcr_c != pc_v);
        fails[6] = ((rm_c != '0) && (wm_c != '0)) || !mask_ok(rm_c) || !mask_ok(wm_c);
        fails[7] = rvfi_trap[c];
        fails[8] = (insn_c[1:0] != 2'b11) && (insn_c[31:16] != '0);
`ifdef RVFI_HALT_CHECK_EN
        fails[9] = halted_v;
        if (rvfi_halt[c]) halted_v = 1'b1;
`endif

        // Lowest failing check id on this channel
        chk = '0;
        for (int k = 9; k >= 1; k--) begin
          if (fails[k]) chk = 4'(k);
        end
        if (first_v == '0 && chk != '0) first_v = {8'h00, chk, 4'(c)};

        // State updates proceed even when a check fails.
        ord_v   = ord_c + 64'd1;
        pc_v    = pcw_c;
        known_v = 1'b1;
        if (rd_c != 5'd0) begin
          shadow_v[rd_c] = rd_d;
          sval_v[rd_c]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      errcode     <= '0;
      exp_order_q <= '0;
      exp_pc_q    <= '0;
      pc_known_q  <= 1'b0;
      sval_q      <= '0;
      halted_q    <= 1'b0;
      for (int r = 0; r < 32; r++) shadow_q[r] <= '0;
    end else begin
      exp_order_q <= ord_v;
      exp_pc_q    <= pc_v;
      pc_known_q  <= known_v;
      sval_q      <= sval_v;
      halted_q    <= halted_v;
      for (int r = 0; r < 32; r++) shadow_q[r] <= shadow_v[r];
      // Sticky: only the first violation is ever recorded.
      if (errcode == '0) errcode <= first_v;
    end
  end

endmodule

// File: tb/tb_riscv_formal_monitor_rv32imc.sv
// Directed, table-driven bench for riscv_formal_monitor_rv32imc.
module tb_riscv_formal_monitor_rv32imc;
  localparam int NRET = 8;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  logic                 clock;
  logic                 reset;
  logic [NRET-1:0]      rvfi_valid;
  logic [64*NRET-1:0]   rvfi_order;
  logic [ILEN*NRET-1:0] rvfi_insn;
  logic [NRET-1:0]      rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mem_extamo;
  logic [2*NRET-1:0]    rvfi_mode;
  logic [5*NRET-1:0]    rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [XLEN*NRET-1:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [XLEN*NRET-1:0] rvfi_pc_rdata, rvfi_pc_wdata;
  logic [XLEN*NRET-1:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [4*NRET-1:0]    rvfi_mem_rmask, rvfi_mem_wmask;
  logic [15:0]          errcode;

  riscv_formal_monitor_rv32imc #(.NRET(NRET), .XLEN(XLEN), .ILEN(ILEN)) dut (
    .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_extamo(rvfi_mem_extamo),
    .errcode(errcode)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_rdata;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
  } chan_t;

  typedef struct packed {
    logic            do_reset;
    chan_t [NRET-1:0] ch;
    logic [15:0]     exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[20];
  int nv = 0;
  vec_t v;
  logic [15:0] exp_q[$];

  // Clean commit: NOP, given order and PC, falls through to PC+4.
  function automatic chan_t cc(input logic [63:0] ord, input logic [31:0] pc);
    chan_t t;
    t = '0;
    t.valid = 1'b1;
    t.order = ord;
    t.insn = 32'h0000_0013;
    t.pc_rdata = pc;
    t.pc_wdata = pc + 32'd4;
    return t;
  endfunction

  // Driver tasks
  task automatic clear_inputs();
    rvfi_valid = '0; rvfi_order = '0; rvfi_insn = '0; rvfi_trap = '0;
    rvfi_halt = '0; rvfi_intr = '0; rvfi_mode = '0; rvfi_mem_extamo = '0;
    rvfi_rs1_addr = '0; rvfi_rs2_addr = '0; rvfi_rd_addr = '0;
    rvfi_rs1_rdata = '0; rvfi_rs2_rdata = '0; rvfi_rd_wdata = '0;
    rvfi_pc_rdata = '0; rvfi_pc_wdata = '0; rvfi_mem_addr = '0;
    rvfi_mem_rdata = '0; rvfi_mem_wdata = '0;
    rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
  endtask

  task automatic drive_chan(input int c, input chan_t r);
    rvfi_valid[c]              = r.valid;
    rvfi_order[c*64 +: 64]     = r.order;
    rvfi_insn[c*32 +: 32]      = r.insn;
    rvfi_trap[c]               = r.trap;
    rvfi_halt[c]               = r.halt;
    rvfi_rs1_addr[c*5 +: 5]    = r.rs1_addr;
    rvfi_rs1_rdata[c*32 +: 32] = r.rs1_rdata;
    rvfi_rs2_addr[c*5 +: 5]    = r.rs2_addr;
    rvfi_rs2_rdata[c*32 +: 32] = r.rs2_rdata;
    rvfi_rd_addr[c*5 +: 5]     = r.rd_addr;
    rvfi_rd_wdata[c*32 +: 32]  = r.rd_wdata;
    rvfi_pc_rdata[c*32 +: 32]  = r.pc_rdata;
    rvfi_pc_wdata[c*32 +: 32]  = r.pc_wdata;
    rvfi_mem_rmask[c*4 +: 4]   = r.rmask;
    rvfi_mem_wmask[c*4 +: 4]   = r.wmask;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Scoreboard compare against the head of exp_q
  task automatic check(input string name);
    logic [15:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected value queued, errcode=%h", name, errcode);
    end else begin
      e = exp_q.pop_front();
      if (errcode !== e) begin
        n_fail++;
        $display("FAIL %s: errcode=%h expected=%h", name, errcode, e);
      end
    end
  endtask

  // One cycle of commits; errcode is sampled at the following negedge.
  task automatic apply_vec(input vec_t x, input string name);
    if (x.do_reset) do_reset();
    clear_inputs();
    for (int c = 0; c < NRET; c++) drive_chan(c, x.ch[c]);
    @(negedge clock);
    clear_inputs();
    exp_q.push_back(x.exp_err);
    check(name);
  endtask

  task automatic add_vec(input vec_t x);
    vecs[nv] = x;
    nv++;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();

    // ---- vector table ----
    // 0: four chained clean commits
    v = '0; v.do_reset = 1'b1;
    for (int i = 0; i < 4; i++) v.ch[i] = cc(64'(i), 32'h6000_0000 + 32'(4*i));
    v.exp_err = 16'h0000; add_vec(v);
    // 1: continue with order 4 at the next PC
    v = '0; v.ch[0] = cc(64'd4, 32'h6000_0010); v.exp_err = 16'h0000; add_vec(v);
    // 2,3: order gap 1 -> 3
    v = '0; v.do_reset = 1'b1; v.ch[0] = cc(64'd0, 32'h100); v.ch[1] = cc(64'd1, 32'h104);
    v.exp_err = 16'h0000; add_vec(v);
    v = '0; v.ch[0] = cc(64'd3, 32'h108); v.exp_err = 16'h0010; add_vec(v);
    // 4: a later x0 violation must not overwrite the sticky code
    v = '0; v.ch[0] = cc(64'd4, 32'h10C); v.ch[0].rd_wdata = 32'h1; v.exp_err = 16'h0010; add_vec(v);
    // 5: same-cycle forwarding of x5 to ch1 rs1
    v = '0; v.do_reset = 1'b1;
    v.ch[0] = cc(64'd0, 32'h1000); v.ch[0].rd_addr = 5'd5; v.ch[0].rd_wdata = 32'hDEAD_BEEF;
    v.ch[1] = cc(64'd1, 32'h1004); v.ch[1].rs1_addr = 5'd5; v.ch[1].rs1_rdata = 32'h0;
    v.exp_err = 16'h0031; add_vec(v);
    // 6: x0 write on ch2
    v = '0; v.do_reset = 1'b1;
    for (int i = 0; i < 3; i++) v.ch[i] = cc(64'(i), 32'h200 + 32'(4*i));
    v.ch[2].rd_wdata = 32'h1; v.exp_err = 16'h0022; add_vec(v);
    // 7: PC break on ch1
    v = '0; v.do_reset = 1'b1; v.ch[0] = cc(64'd0, 32'h100); v.ch[1] = cc(64'd1, 32'h108);
    v.exp_err = 16'h0051; add_vec(v);
    // 8: rs2 forwarding mismatch
    v = '0; v.do_reset = 1'b1;
    v.ch[0] = cc(64'd0, 32'h300); v.ch[0].rd_addr = 5'd7; v.ch[0].rd_wdata = 32'h11;
    v.ch[1] = cc(64'd1, 32'h304); v.ch[1].rs2_addr = 5'd7; v.ch[1].rs2_rdata = 32'h12;
    v.exp_err = 16'h0041; add_vec(v);
    // 9: read and write mask together
    v = '0; v.do_reset = 1'b1; v.ch[0] = cc(64'd0, 32'h400);
    v.ch[0].rmask = 4'b0001; v.ch[0].wmask = 4'b0001; v.exp_err = 16'h0060; add_vec(v);
    // 10: illegal mask shape on ch1
    v = '0; v.do_reset = 1'b1; v.ch[0] = cc(64'd0, 32'h400); v.ch[1] = cc(64'd1, 32'h404);
    v.ch[1].rmask = 4'b0101; v.exp_err = 16'h0061; add_vec(v);
    // 11: trap
    v = '0; v.do_reset = 1'b1; v.ch[0] = cc(64'd0, 32'h500); v.ch[0].trap = 1'b1;
    v.exp_err = 16'h0070; add_vec(v);
    // 12: compressed insn with nonzero upper half on ch3
    v = '0; v.do_reset = 1'b1;
    for (int i = 0; i < 4; i++) v.ch[i] = cc(64'(i), 32'h600 + 32'(4*i));
    v.ch[3].insn = 32'h0001_0001; v.exp_err = 16'h0083; add_vec(v);
    // 13: priority: ch1 has checks 2 and 7, ch2 has check 1
    v = '0; v.do_reset = 1'b1; v.ch[0] = cc(64'd0, 32'h2000);
    v.ch[1] = cc(64'd1, 32'h2004); v.ch[1].trap = 1'b1; v.ch[1].rd_wdata = 32'h5;
    v.ch[2] = cc(64'd5, 32'h2008); v.exp_err = 16'h0021; add_vec(v);
    // 14: invalid channel with garbage between two valid ones
    v = '0; v.do_reset = 1'b1; v.ch[0] = cc(64'd0, 32'h3000);
    v.ch[1] = cc(64'd99, 32'hBAD0); v.ch[1].valid = 1'b0; v.ch[1].trap = 1'b1;
    v.ch[2] = cc(64'd1, 32'h3004); v.exp_err = 16'h0000; add_vec(v);
    // 15..17: unwritten regs are unchecked; written ones are checked across cycles
    v = '0; v.do_reset = 1'b1; v.ch[0] = cc(64'd0, 32'h4000);
    v.ch[0].rs1_addr = 5'd9; v.ch[0].rs1_rdata = 32'h55;
    v.ch[0].rs2_addr = 5'd10; v.ch[0].rs2_rdata = 32'h66; v.exp_err = 16'h0000; add_vec(v);
    v = '0; v.ch[0] = cc(64'd1, 32'h4004); v.ch[0].rd_addr = 5'd9; v.ch[0].rd_wdata = 32'h77;
    v.ch[1] = cc(64'd2, 32'h4008); v.ch[1].rs1_addr = 5'd9; v.ch[1].rs1_rdata = 32'h77;
    v.ch[1].rmask = 4'b1111; v.exp_err = 16'h0000; add_vec(v);
    v = '0; v.ch[0] = cc(64'd3, 32'h400C); v.ch[0].rs2_addr = 5'd9; v.ch[0].rs2_rdata = 32'h77;
    v.ch[0].wmask = 4'b0011;
    v.ch[1] = cc(64'd4, 32'h4010); v.ch[1].rs1_addr = 5'd9; v.ch[1].rs1_rdata = 32'h78;
    v.exp_err = 16'h0031; add_vec(v);

    // ---- reset state ----
    @(negedge clock);
    exp_q.push_back(16'h0000);
    check("reset_state");

    // ---- apply table ----
    for (int i = 0; i < nv; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // ---- async reset mid-cycle while an error is held (0x0031 from vec17) ----
    #2 reset = 1'b0;
    #1 exp_q.push_back(16'h0000);
    check("async_reset_clear");
    @(negedge clock);
    reset = 1'b1;
    v = '0; v.ch[0] = cc(64'd0, 32'h5000); v.exp_err = 16'h0000;
    apply_vec(v, "order_restart");
    v = '0; v.ch[0] = cc(64'd1, 32'h5004); v.exp_err = 16'h0000;
    apply_vec(v, "order_restart_next");

    // ---- all eight channels in one cycle ----
    v = '0; v.do_reset = 1'b1;
    for (int i = 0; i < NRET; i++) v.ch[i] = cc(64'(i), 32'h7000 + 32'(4*i));
    v.exp_err = 16'h0000;
    apply_vec(v, "eight_wide");
    v = '0; v.ch[0] = cc(64'd8, 32'h7020); v.exp_err = 16'h0000;
    apply_vec(v, "eight_wide_next");
    v = '0; v.ch[0] = cc(64'd10, 32'h7024); v.exp_err = 16'h0010;
    apply_vec(v, "eight_wide_gap");

    // ---- halt followed by a commit on a higher channel ----
    v = '0; v.do_reset = 1'b1;
    v.ch[0] = cc(64'd0, 32'h8000); v.ch[0].halt = 1'b1; v.ch[1] = cc(64'd1, 32'h8004);
`ifdef RVFI_HALT_CHECK_EN
    v.exp_err = 16'h0091;
`else
    v.exp_err = 16'h0000;
`endif
    apply_vec(v, "halt_then_commit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
